// File: rtl/sched_table_insert_if.sv
// Insert and head-pop handshake bundle for the sorted schedule-table writer.
interface sched_table_insert_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             ins_valid;
    logic             ins_ready;
    logic [3:0]       ins_pos;
    logic [WIDTH-1:0] ins_info;
    logic [3:0]       ins_tid;
    logic             pop_valid;
    logic             pop_ready;
    logic [WIDTH-1:0] pop_info;
    logic [3:0]       pop_tid;

    modport master (
        output ins_valid, ins_pos, ins_info, ins_tid, pop_valid,
        input  ins_ready, pop_ready, pop_info, pop_tid
    );

    modport slave (
        input  ins_valid, ins_pos, ins_info, ins_tid, pop_valid,
        output ins_ready, pop_ready, pop_info, pop_tid
    );
endinterface

// File: rtl/sched_table_insert.sv
// Deadline-ordered task table: shift-then-write insertion at a searched slot.
// Define SCHED_POP_EN to enable the head-pop port; otherwise the table only grows until reset.
module sched_table_insert #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    sched_table_insert_if.slave         bus,
    output logic [DEPTH-1:0][WIDTH-1:0] schden_info,
    output logic [DEPTH-1:0][3:0]       schden_tid,
    output logic [4:0]                  count,
    output logic                        empty,
    output logic                        full,
    output logic                        busy
);

    typedef enum logic [1:0] {StIdle, StShift, StWrite} state_e;

    state_e                      state_q;
    logic [3:0]                  idx_q;
    logic [3:0]                  pos_q;
    logic [WIDTH-1:0]            info_q;
    logic [3:0]                  tid_q;
    logic [4:0]                  count_q;
    logic [DEPTH-1:0][WIDTH-1:0] info_tbl_q;
    logic [DEPTH-1:0][3:0]       tid_tbl_q;

    logic       idle;
    logic       pop_active;
    logic       ins_fire;
    logic [4:0] pos_clamp;

    assign idle  = (state_q == StIdle);
    assign empty = (count_q == 5'd0);
    assign full  = (count_q == 5'(DEPTH));
    assign busy  = !idle;

`ifdef SCHED_POP_EN
    logic [WIDTH-1:0] pop_info_q;
    logic [3:0]       pop_tid_q;

    assign pop_active   = idle && bus.pop_valid && !empty;
    assign bus.pop_info = pop_info_q;
    assign bus.pop_tid  = pop_tid_q;
`else
    logic unused_pop_valid;

    assign unused_pop_valid = bus.pop_valid;
    assign pop_active       = 1'b0;
    assign bus.pop_info     = '0;
    assign bus.pop_tid      = '0;
`endif

    // Pop wins over a simultaneous insert; the insert simply waits for ready.
    assign bus.pop_ready = pop_active;
    assign bus.ins_ready = idle && !full && !pop_active;
    assign ins_fire      = bus.ins_valid && bus.ins_ready;

    // Positions past the last valid entry append, so the table never has gaps.
    assign pos_clamp = ({1'b0, bus.ins_pos} > count_q) ? count_q : {1'b0, bus.ins_pos};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            pos_q      <= '0;
            info_q     <= '0;
            tid_q      <= '0;
            count_q    <= '0;
            info_tbl_q <= '1;
            tid_tbl_q  <= '0;
`ifdef SCHED_POP_EN
            pop_info_q <= '0;
            pop_tid_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
`ifdef SCHED_POP_EN
                    if (pop_active) begin
                        pop_info_q <= info_tbl_q[0];
                        pop_tid_q  <= tid_tbl_q[0];
                        for (int i = 0; i < DEPTH - 1; i++) begin
                            info_tbl_q[i] <= info_tbl_q[i+1];
                            tid_tbl_q[i]  <= tid_tbl_q[i+1];
                        end
                        info_tbl_q[DEPTH-1] <= '1;
                        tid_tbl_q[DEPTH-1]  <= '0;
                        count_q             <= count_q - 5'd1;
                    end else
`endif
                    if (ins_fire) begin
                        info_q  <= bus.ins_info;
                        tid_q   <= bus.ins_tid;
                        pos_q   <= pos_clamp[3:0];
                        idx_q   <= count_q[3:0] - 4'd1;
                        state_q <= (pos_clamp == count_q) ? StWrite : StShift;
                    end
                end
                StShift: begin
                    info_tbl_q[idx_q + 4'd1] <= info_tbl_q[idx_q];
                    tid_tbl_q[idx_q + 4'd1]  <= tid_tbl_q[idx_q];
                    if (idx_q == pos_q) begin
                        state_q <= StWrite;
                    end else begin
                        idx_q <= idx_q - 4'd1;
                    end
                end
                StWrite: begin
                    info_tbl_q[pos_q] <= info_q;
                    tid_tbl_q[pos_q]  <= tid_q;
                    count_q           <= count_q + 5'd1;
                    state_q           <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign schden_info = info_tbl_q;
    assign schden_tid  = tid_tbl_q;
    assign count       = count_q;

endmodule

// File: tb/tb_sched_table_insert.sv
// Scoreboard bench for sched_table_insert: stimulus queues expectations, a monitor checks them.
module tb_sched_table_insert;

    localparam int DEPTH = 16;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sched_table_insert_if #(.WIDTH(WIDTH)) bus ();

    logic [DEPTH-1:0][WIDTH-1:0] schden_info;
    logic [DEPTH-1:0][3:0]       schden_tid;
    logic [4:0]                  count;
    logic                        empty;
    logic                        full;
    logic                        busy;

    sched_table_insert #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .schden_info (schden_info),
        .schden_tid  (schden_tid),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DEPTH-1:0][WIDTH-1:0] info;
        logic [DEPTH-1:0][3:0]       tid;
        logic [4:0]                  cnt;
        int                          lat;
        logic [WIDTH-1:0]            pinfo;
        logic [3:0]                  ptid;
    } exp_t;

    exp_t ins_q[$];
    exp_t pop_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_cyc = 0;

    // Reference table
    logic [DEPTH-1:0][WIDTH-1:0] m_info;
    logic [DEPTH-1:0][3:0]       m_tid;
    int                          m_cnt;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event, want expected event", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    exp_t e;
    logic busy_prev = 1'b0;
    logic pop_pend  = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            ins_q.delete();
            pop_q.delete();
            busy_prev = 1'b0;
            pop_pend  = 1'b0;
        end else begin
            if (pop_pend) begin
                if (pop_q.size() == 0) begin
                    fail("pop_unexpected");
                end else begin
                    e = pop_q.pop_front();
                    check("pop_info", 512'(bus.pop_info), 512'(e.pinfo));
                    check("pop_tid", 512'(bus.pop_tid), 512'(e.ptid));
                    check("pop_table", 512'(schden_info), 512'(e.info));
                    check("pop_count", 512'(count), 512'(e.cnt));
                end
                pop_pend = 1'b0;
            end
            if (busy_prev && !busy) begin
                if (ins_q.size() == 0) begin
                    fail("ins_unexpected_done");
                end else begin
                    e = ins_q.pop_front();
                    check("ins_table_info", 512'(schden_info), 512'(e.info));
                    check("ins_table_tid", 512'(schden_tid), 512'(e.tid));
                    check("ins_count", 512'(count), 512'(e.cnt));
                    check("ins_latency", 512'(cyc - acc_cyc), 512'(e.lat));
                end
            end
            if (bus.ins_valid && bus.ins_ready) acc_cyc = cyc;
            if (bus.pop_ready) pop_pend = 1'b1;
            busy_prev = busy;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.ins_valid = 1'b0;
        bus.pop_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_info = '1;
        m_tid  = '0;
        m_cnt  = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) fail("busy_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic do_insert(input int pos, input logic [WIDTH-1:0] info, input logic [3:0] tid);
        int   n = 0;
        int   p;
        exp_t x;
        bus.ins_pos   = 4'(pos);
        bus.ins_info  = info;
        bus.ins_tid   = tid;
        bus.ins_valid = 1'b1;
        while (!bus.ins_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.ins_ready) begin
            fail("ins_accept_timeout");
            bus.ins_valid = 1'b0;
            return;
        end
        p = (pos > m_cnt) ? m_cnt : pos;
        x.lat = 2 + (m_cnt - p);
        for (int i = DEPTH - 1; i > p; i--) begin
            m_info[i] = m_info[i-1];
            m_tid[i]  = m_tid[i-1];
        end
        m_info[p] = info;
        m_tid[p]  = tid;
        m_cnt++;
        x.info  = m_info;
        x.tid   = m_tid;
        x.cnt   = 5'(m_cnt);
        x.pinfo = '0;
        x.ptid  = '0;
        ins_q.push_back(x);
        @(posedge clk);
        #1 bus.ins_valid = 1'b0;
        wait_idle();
    endtask

    logic [DEPTH-1:0][WIDTH-1:0] h_info;
    logic [DEPTH-1:0][3:0]       h_tid;

    initial begin
        bus.ins_valid = 1'b0;
        bus.pop_valid = 1'b0;
        bus.ins_pos   = '0;
        bus.ins_info  = '0;
        bus.ins_tid   = '0;
        do_reset();

        // Reset state
        check("rst_info", 512'(schden_info), {512{1'b1}});
        check("rst_tid", 512'(schden_tid), 512'(0));
        check("rst_count", 512'(count), 512'(0));
        check("rst_empty", 512'(empty), 512'(1));
        check("rst_full", 512'(full), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_ins_ready", 512'(bus.ins_ready), 512'(1));
        check("rst_pop_ready", 512'(bus.pop_ready), 512'(0));
        check("rst_pop_info", 512'(bus.pop_info), 512'(0));
        check("rst_pop_tid", 512'(bus.pop_tid), 512'(0));

        // Single insert into empty table
        do_insert(0, 32'h50, 4'd3);
        h_info    = '1;
        h_info[0] = 32'h50;
        h_tid     = '0;
        h_tid[0]  = 4'd3;
        check("first_info", 512'(schden_info), 512'(h_info));
        check("first_tid", 512'(schden_tid), 512'(h_tid));
        check("first_empty", 512'(empty), 512'(0));

        // Mid-table insert with one shift
        do_reset();
        do_insert(0, 32'h10, 4'd1);
        do_insert(1, 32'h20, 4'd2);
        do_insert(2, 32'h40, 4'd4);
        do_insert(2, 32'h30, 4'd3);
        h_info = '1;
        h_info[0] = 32'h10; h_info[1] = 32'h20; h_info[2] = 32'h30; h_info[3] = 32'h40;
        h_tid = '0;
        h_tid[0] = 4'd1; h_tid[1] = 4'd2; h_tid[2] = 4'd3; h_tid[3] = 4'd4;
        check("mid_info", 512'(schden_info), 512'(h_info));
        check("mid_tid", 512'(schden_tid), 512'(h_tid));
        check("mid_count", 512'(count), 512'(4));

        // Out-of-range position clamps to an append
        do_reset();
        do_insert(0, 32'h10, 4'd1);
        do_insert(1, 32'h20, 4'd2);
        do_insert(9, 32'h25, 4'd5);
        check("clamp_slot2", 512'(schden_info[2]), 512'(32'h25));
        check("clamp_slot3", 512'(schden_info[3]), 512'(32'hFFFF_FFFF));
        check("clamp_count", 512'(count), 512'(3));

        // Fill to 16 with a mix of positions
        for (int i = 0; i < 13; i++) begin
            do_insert((i * 7) % 16, 32'h100 + 32'(i), 4'(i));
        end
        check("full_flag", 512'(full), 512'(1));
        check("full_count", 512'(count), 512'(16));
        check("full_ins_ready", 512'(bus.ins_ready), 512'(0));
        bus.ins_pos   = 4'd0;
        bus.ins_info  = 32'h1;
        bus.ins_tid   = 4'd9;
        bus.ins_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("full_hold_info", 512'(schden_info), 512'(m_info));
            check("full_hold_busy", 512'(busy), 512'(0));
        end
        bus.ins_valid = 1'b0;
        check("full_hold_count", 512'(count), 512'(16));

        // Pop against a simultaneous insert
        do_reset();
        do_insert(0, 32'h10, 4'd1);
        do_insert(1, 32'h20, 4'd2);
`ifdef SCHED_POP_EN
        begin
            exp_t x;
            bus.ins_pos   = 4'd1;
            bus.ins_info  = 32'h30;
            bus.ins_tid   = 4'd3;
            bus.ins_valid = 1'b1;
            bus.pop_valid = 1'b1;
            #1;
            check("pop_ready_hi", 512'(bus.pop_ready), 512'(1));
            check("pop_blocks_ins", 512'(bus.ins_ready), 512'(0));
            x.pinfo = m_info[0];
            x.ptid  = m_tid[0];
            for (int i = 0; i < DEPTH - 1; i++) begin
                m_info[i] = m_info[i+1];
                m_tid[i]  = m_tid[i+1];
            end
            m_info[DEPTH-1] = '1;
            m_tid[DEPTH-1]  = '0;
            m_cnt--;
            x.info = m_info;
            x.tid  = m_tid;
            x.cnt  = 5'(m_cnt);
            x.lat  = 0;
            pop_q.push_back(x);
            @(posedge clk);
            #1 bus.pop_valid = 1'b0;
            check("pop_info_hand", 512'(bus.pop_info), 512'(32'h10));
            check("pop_slot0_hand", 512'(schden_info[0]), 512'(32'h20));
            check("pop_ins_ready_after", 512'(bus.ins_ready), 512'(1));
            do_insert(1, 32'h30, 4'd3);
            check("pop_then_ins_slot1", 512'(schden_info[1]), 512'(32'h30));
        end
`else
        bus.pop_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("nopop_ready", 512'(bus.pop_ready), 512'(0));
            check("nopop_info", 512'(bus.pop_info), 512'(0));
            check("nopop_count", 512'(count), 512'(2));
        end
        bus.pop_valid = 1'b0;
`endif

        // Reset during the second shift cycle
        do_reset();
        for (int i = 0; i < 5; i++) do_insert(i, 32'h10 * 32'(i + 1), 4'(i + 1));
        bus.ins_pos   = 4'd0;
        bus.ins_info  = 32'h05;
        bus.ins_tid   = 4'd7;
        bus.ins_valid = 1'b1;
        @(posedge clk);
        #1 bus.ins_valid = 1'b0;
        check("shift_busy", 512'(busy), 512'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_info", 512'(schden_info), {512{1'b1}});
        check("abort_tid", 512'(schden_tid), 512'(0));
        check("abort_count", 512'(count), 512'(0));
        check("abort_busy", 512'(busy), 512'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        m_info = '1;
        m_tid  = '0;
        m_cnt  = 0;
        do_insert(3, 32'h77, 4'd6);
        check("recover_slot0", 512'(schden_info[0]), 512'(32'h77));

        check("ins_q_drained", 512'(ins_q.size()), 512'(0));
        check("pop_q_drained", 512'(pop_q.size()), 512'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
